uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one uart_tx instance between NUM_REQ byte producers (e.g. command echo, status reporter, debug).
- Uses per-requester valid/ready byte handshakes and round-robin arbitration. A message lock keeps one owner until its byte flagged last has been sent.
- Sequences uart_tx: loads data_in, pulses send for one cycle, then tracks busy through rise and fall.
- Sits between producers and uart_tx; baud_gen/baud_tick is not touched.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- BUSY_TIMEOUT, 16: clk cycles allowed from the send pulse to busy rising before a timeout is declared.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- req_valid  input  NUM_REQ  requester i has a byte.
- req_data  input  8*NUM_REQ  requester i byte in bits [8i+7:8i].
- req_last  input  NUM_REQ  byte from requester i ends its message.
- req_ready  output  NUM_REQ  byte from requester i accepted this cycle.
- grant  output  NUM_REQ  one-hot current owner; 0 when idle.
- tx_data  output  8  to uart_tx data_in.
- tx_send  output  1  to uart_tx send; single-cycle pulse.
- tx_busy  input  1  from uart_tx busy.
- active  output  1  high in any state other than IDLE.
- err_timeout  output  1  one-cycle pulse when busy fails to rise.

Behaviour:
- Reset (reset==0 at a clk edge): state=IDLE, grant=0, req_ready=0, tx_data=8'h00, tx_send=0, active=0, err_timeout=0, last_owner=NUM_REQ-1, timeout count=0. This applies mid-transfer as well. The uart_tx frame already launched is not aborted, but the next SEND waits for tx_busy==0.
- Handshake rules:
  - A transfer occurs on a cycle with req_valid[i]&&req_ready[i].
  - A requester holds req_valid and req_data stable until the transfer.
  - req_ready is combinational: grant[i] && state==ACCEPT && req_valid[i].
- States:
  - IDLE: if any req_valid, select the first set bit, searching upward circularly from last_owner+1. Register grant=onehot(W), go to ACCEPT. Otherwise stay.
  - ACCEPT: on transfer, register tx_data<=req_data[W] and last_q<=req_last[W], then go to SEND. If req_valid[W] is low, hold ACCEPT with the grant kept (message lock). Other requesters are not served.
  - SEND: if tx_busy==0, drive tx_send=1 for this cycle only, clear the timeout counter, go to WAIT_HI. If tx_busy==1, hold with tx_send=0.
  - WAIT_HI: if tx_busy==1, go to WAIT_LO. Otherwise increment the counter. When the counter reaches BUSY_TIMEOUT-1, pulse err_timeout, set last_owner<=W, set grant<=0, and go to IDLE. This drops the message lock.
  - WAIT_LO: when tx_busy==0 and last_q==1, set last_owner<=W, grant<=0, and go to IDLE. When tx_busy==0 and last_q==0, go to ACCEPT with the grant kept.
- Latency: req_valid rising in IDLE at cycle 0 gives grant and req_ready at cycle 1 (transfer), and tx_send at cycle 2.
  - Between bytes of a locked message: tx_busy falls at cycle n, so ACCEPT is at n+1 and tx_send at n+2 (if valid is held).
- Ties and new arrivals:
  - Simultaneous requests in IDLE are resolved only by the round-robin pointer.
  - Requests arriving during a locked message wait and are never dropped.
- tx_data holds its last value when idle.
- grant is never multi-hot.
- tx_send is never high on two consecutive cycles.

Test Plan:
- Single byte: req_valid[0]=1, req_data=8'h53, req_last=1 -> req_ready[0] high for 1 cycle, tx_data=8'h53, one tx_send pulse, grant=0 and active=0 after busy falls.
- Round-robin: req0 and req2 valid together, both last=1, after reset -> req0 served first, then req2. A following req0+req2 pair -> req0 first again (pointer at 2).
- Message lock: req1 sends "S","E","N","D" with last on "D"; req0 raises valid during "E" -> four tx_send pulses in order 8'h53, 8'h45, 8'h4E, 8'h44 with grant=4'b0010 throughout; req0 is granted only after "D" completes.
- Timeout: tx_busy tied 0, one byte sent -> err_timeout pulses exactly BUSY_TIMEOUT-1 cycles after the tx_send cycle, then IDLE with grant=0.
- Busy on entry: tx_busy=1 when SEND is reached -> tx_send stays 0 until tx_busy drops, then one pulse.
- Reset mid-message: reset=0 for one clk during WAIT_LO of byte 2 of 4 -> next cycle all outputs at reset values. After release, a new req_valid[3] is granted first.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx between NUM_REQ byte producers.
// An owner keeps the grant until its last-flagged byte has left the transmitter.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned BUSY_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic [7:0]           tx_data,
    output logic                 tx_send,
    input  logic                 tx_busy,
    output logic                 active,
    output logic                 err_timeout
);

    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CW = $clog2(BUSY_TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LIMIT = CW'(BUSY_TIMEOUT - 2);
    localparam logic [IW-1:0] LAST_RST  = IW'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ACCEPT  = 3'd1,
        SEND    = 3'd2,
        WAIT_HI = 3'd3,
        WAIT_LO = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [IW-1:0]        owner_q, owner_d;
    logic [IW-1:0]        last_owner_q, last_owner_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic                 last_q, last_d;
    logic [CW-1:0]        cnt_q, cnt_d;

    logic [IW-1:0]        cand;
    logic [IW-1:0]        pick_idx;
    logic                 pick_found;

    assign grant     = grant_q;
    assign tx_data   = tx_data_q;
    assign active    = (state_q != IDLE);
    assign req_ready = grant_q & req_valid & {NUM_REQ{state_q == ACCEPT}};

    // Round-robin pick: first valid requester searching upward from last_owner+1.
    always_comb begin
        cand       = '0;
        pick_idx   = '0;
        pick_found = 1'b0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = IW'((32'(last_owner_q) + k) % NUM_REQ);
            if (!pick_found && req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Next-state, register updates and the single-cycle strobes.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        tx_data_d    = tx_data_q;
        last_d       = last_q;
        cnt_d        = cnt_q;
        tx_send      = 1'b0;
        err_timeout  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    owner_d           = pick_idx;
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    state_d           = ACCEPT;
                end
            end
            ACCEPT: begin
                if (req_valid[owner_q]) begin
                    tx_data_d = req_data[{owner_q, 3'b000} +: 8];
                    last_d    = req_last[owner_q];
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (!tx_busy) begin
                    tx_send = 1'b1;
                    cnt_d   = '0;
                    state_d = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (tx_busy) begin
                    state_d = WAIT_LO;
                end else if (cnt_q == CNT_LIMIT) begin
                    // Transmitter never acknowledged: report and release the lock.
                    err_timeout  = 1'b1;
                    last_owner_d = owner_q;
                    grant_d      = '0;
                    state_d      = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WAIT_LO: begin
                if (!tx_busy) begin
                    if (last_q) begin
                        last_owner_d = owner_q;
                        grant_d      = '0;
                        state_d      = IDLE;
                    end else begin
                        state_d = ACCEPT;
                    end
                end
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            owner_q      <= '0;
            last_owner_q <= LAST_RST;
            tx_data_q    <= 8'h00;
            last_q       <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            tx_data_q    <= tx_data_d;
            last_q       <= last_d;
            cnt_q        <= cnt_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a behavioural uart_tx busy model.
module tb_uart_tx_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned BT = 16;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   grant;
    logic [7:0]     tx_data;
    logic           tx_send;
    logic           tx_busy;
    logic           active;
    logic           err_timeout;

    uart_tx_arbiter #(.NUM_REQ(N), .BUSY_TIMEOUT(BT)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .grant(grant), .tx_data(tx_data),
        .tx_send(tx_send), .tx_busy(tx_busy), .active(active), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Pending stimulus per producer and expected bytes per producer: {last, data}.
    logic [8:0]  msg_q [N][$];
    logic [8:0]  exp_q [N][$];
    int          win_log[$];
    logic [11:0] send_log[$];

    int checks = 0, errors = 0;
    int sends = 0, err_cnt = 0, err_cyc = 0, send_cyc = 0, pushed = 0;
    int model_last = N - 1;
    bit locked = 1'b0;
    int lock_owner = 0;
    logic [N-1:0] prev_grant = '0, prev_valid = '0, ready_seen = '0;
    bit prev_send = 1'b0;
    int gap[N];
    int gapmax = 0;
    bit uart_force = 1'b0;
    logic force_val = 1'b0;
    int rise_max = 0, len_min = 3, len_max = 3;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v = '0;
        if (i >= 0 && i < N) v[i] = 1'b1;
        return v;
    endfunction

    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic int first_set(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return 0;
    endfunction

    // uart_tx model: busy rises some cycles after each send and stays up a while.
    initial begin : uart_model
        int seen, rcnt, hcnt;
        bit pend;
        seen = 0; rcnt = 0; hcnt = 0; pend = 1'b0;
        tx_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (uart_force) begin
                seen    = sends;
                pend    = 1'b0;
                hcnt    = 0;
                tx_busy = force_val;
            end else begin
                if (sends != seen) begin
                    seen = sends;
                    pend = 1'b1;
                    rcnt = int'($urandom_range(rise_max, 0));
                    hcnt = int'($urandom_range(len_max, len_min));
                end
                if (pend) begin
                    if (rcnt == 0) begin
                        tx_busy = 1'b1;
                        pend    = 1'b0;
                    end else begin
                        rcnt--;
                    end
                end else if (tx_busy) begin
                    if (hcnt <= 1) tx_busy = 1'b0;
                    else hcnt--;
                end
            end
        end
    end

    // Monitor: pops expectations on every send and checks arbitration and locking.
    always @(negedge clk) begin
        int owner, w;
        logic [8:0] e;
        ready_seen = req_ready;
        if (!reset) begin
            for (int i = 0; i < N; i++) exp_q[i].delete();
            locked     = 1'b0;
            model_last = N - 1;
            prev_grant = '0;
            prev_valid = '0;
            prev_send  = 1'b0;
        end else begin
            check("grant_not_multihot", 32'($countones(grant) <= 1), 1);
            if (err_timeout) begin
                err_cnt++;
                err_cyc = cyc;
            end
            if (tx_send) begin
                sends++;
                send_cyc = cyc;
                check("send_not_back_to_back", 32'(prev_send), 0);
                check("grant_onehot_at_send", 32'($countones(grant)), 1);
                owner = first_set(grant);
                if (exp_q[owner].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_send: owner %0d data %0h, none expected", owner, tx_data);
                end else begin
                    e = exp_q[owner].pop_front();
                    check("tx_data", 32'(tx_data), 32'(e[7:0]));
                    send_log.push_back({4'(owner), tx_data});
                    if (e[8]) begin
                        locked     = 1'b0;
                        model_last = owner;
                    end
                end
            end
            if (grant != '0 && prev_grant == '0) begin
                w = rr_pick(prev_valid, model_last);
                check("rr_winner", 32'(grant), 32'(onehot(w)));
                win_log.push_back(first_set(grant));
                locked     = 1'b1;
                lock_owner = w;
            end else if (locked) begin
                check("grant_locked", 32'(grant), 32'(onehot(lock_owner)));
            end
            prev_grant = grant;
            prev_valid = req_valid;
            prev_send  = tx_send;
        end
    end

    // One clock of producer activity; expectations are queued when a byte is offered.
    task automatic step();
        logic [8:0] e;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (req_valid[i] && ready_seen[i]) begin
                req_valid[i] = 1'b0;
                gap[i] = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
            end
            if (!req_valid[i]) begin
                if (gap[i] > 0) begin
                    gap[i]--;
                end else if (msg_q[i].size() > 0) begin
                    e = msg_q[i].pop_front();
                    req_valid[i]       = 1'b1;
                    req_data[8*i +: 8] = e[7:0];
                    req_last[i]        = e[8];
                    exp_q[i].push_back(e);
                    pushed++;
                end
            end
        end
        #1;
    endtask

    function automatic bit all_idle();
        for (int i = 0; i < N; i++) begin
            if (msg_q[i].size() != 0 || exp_q[i].size() != 0) return 1'b0;
        end
        return (req_valid == '0) && !active;
    endfunction

    task automatic run_until_idle(input int budget, input string name);
        int n;
        n = 0;
        while (!all_idle() && n < budget) begin
            step();
            n++;
        end
        check(name, 32'(all_idle()), 1);
    endtask

    task automatic clear_producers();
        req_valid = '0;
        for (int i = 0; i < N; i++) begin
            msg_q[i].delete();
            gap[i] = 0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        clear_producers();
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_grant"}, 32'(grant), 0);
        check({tag, "_req_ready"}, 32'(req_ready), 0);
        check({tag, "_tx_data"}, 32'(tx_data), 0);
        check({tag, "_tx_send"}, 32'(tx_send), 0);
        check({tag, "_active"}, 32'(active), 0);
        check({tag, "_err_timeout"}, 32'(err_timeout), 0);
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int s0, w0, e0, n, p0, len;
        logic [11:0] lk_exp[5];
        logic [31:0] rr_exp[4];
        reset     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        for (int i = 0; i < N; i++) gap[i] = 0;

        // Reset values.
        step();
        step();
        check_reset_values("reset");
        reset = 1'b1;

        // Single byte with exact latency.
        msg_q[0].push_back({1'b1, 8'h53});
        step();
        check("single_c0_ready", 32'(req_ready), 0);
        check("single_c0_grant", 32'(grant), 0);
        step();
        check("single_c1_grant", 32'(grant), 32'(4'b0001));
        check("single_c1_ready", 32'(req_ready), 32'(4'b0001));
        step();
        check("single_c2_send", 32'(tx_send), 1);
        check("single_c2_data", 32'(tx_data), 32'h53);
        check("single_c2_ready", 32'(req_ready), 0);
        step();
        check("single_c3_send", 32'(tx_send), 0);
        step();
        step();
        step();
        check("single_c6_active", 32'(active), 1);
        step();
        check("single_c7_active", 32'(active), 0);
        check("single_c7_grant", 32'(grant), 0);
        check("single_c7_data_hold", 32'(tx_data), 32'h53);

        // Round-robin from reset: 0, 2, then 0, 2 again.
        do_reset();
        w0 = win_log.size();
        msg_q[0].push_back({1'b1, 8'hA0});
        msg_q[0].push_back({1'b1, 8'hA1});
        msg_q[2].push_back({1'b1, 8'hC0});
        msg_q[2].push_back({1'b1, 8'hC1});
        run_until_idle(300, "rr_done");
        check("rr_count", 32'(win_log.size() - w0), 4);
        rr_exp = '{32'd0, 32'd2, 32'd0, 32'd2};
        for (int k = 0; k < 4; k++) begin
            if (win_log.size() > w0 + k) check("rr_order", 32'(win_log[w0 + k]), rr_exp[k]);
        end

        // Message lock: req1 sends SEND, req0 arrives during 'E'.
        s0 = send_log.size();
        msg_q[1].push_back({1'b0, 8'h53});
        msg_q[1].push_back({1'b0, 8'h45});
        msg_q[1].push_back({1'b0, 8'h4E});
        msg_q[1].push_back({1'b1, 8'h44});
        n = 0;
        while (!(req_valid[1] && req_data[15:8] == 8'h45) && n < 100) begin
            step();
            n++;
        end
        check("lock_e_offered", 32'(n < 100), 1);
        msg_q[0].push_back({1'b1, 8'h21});
        run_until_idle(300, "lock_done");
        check("lock_count", 32'(send_log.size() - s0), 5);
        lk_exp = '{12'h153, 12'h145, 12'h14E, 12'h144, 12'h021};
        for (int k = 0; k < 5; k++) begin
            if (send_log.size() > s0 + k) check("lock_order", 32'(send_log[s0 + k]), 32'(lk_exp[k]));
        end

        // Timeout: busy never rises.
        uart_force = 1'b1;
        force_val  = 1'b0;
        e0 = err_cnt;
        msg_q[2].push_back({1'b1, 8'hA5});
        n = 0;
        while (err_cnt == e0 && n < 100) begin
            step();
            n++;
        end
        check("timeout_seen", 32'(err_cnt - e0), 1);
        check("timeout_latency", 32'(err_cyc - send_cyc), BT - 1);
        check("timeout_grant", 32'(grant), 0);
        check("timeout_active", 32'(active), 0);
        repeat (5) step();
        check("timeout_single_pulse", 32'(err_cnt - e0), 1);
        run_until_idle(100, "timeout_done");
        uart_force = 1'b0;

        // Busy already high when SEND is reached.
        uart_force = 1'b1;
        force_val  = 1'b1;
        s0 = sends;
        msg_q[3].push_back({1'b1, 8'h3C});
        repeat (10) step();
        check("busy_entry_no_send", 32'(sends - s0), 0);
        check("busy_entry_active", 32'(active), 1);
        uart_force = 1'b0;
        run_until_idle(100, "busy_entry_done");
        check("busy_entry_one_send", 32'(sends - s0), 1);

        // Reset during WAIT_LO of byte 2 of 4.
        s0 = sends;
        msg_q[1].push_back({1'b0, 8'h31});
        msg_q[1].push_back({1'b0, 8'h32});
        msg_q[1].push_back({1'b0, 8'h33});
        msg_q[1].push_back({1'b1, 8'h34});
        n = 0;
        while (sends - s0 < 2 && n < 200) begin
            step();
            n++;
        end
        check("midreset_two_sent", 32'(sends - s0), 2);
        step();
        check("midreset_active_before", 32'(active), 1);
        reset = 1'b0;
        clear_producers();
        step();
        check_reset_values("midreset");
        reset = 1'b1;
        w0 = win_log.size();
        msg_q[3].push_back({1'b1, 8'h77});
        run_until_idle(200, "midreset_done");
        check("midreset_wins", 32'(win_log.size() - w0), 1);
        if (win_log.size() > w0) check("midreset_owner", 32'(win_log[w0]), 3);

        // Randomized traffic against the scoreboard.
        gapmax   = 3;
        rise_max = 3;
        len_min  = 1;
        len_max  = 5;
        p0 = pushed;
        s0 = sends;
        e0 = err_cnt;
        for (int i = 0; i < N; i++) begin
            for (int m = 0; m < 5; m++) begin
                len = int'($urandom_range(3, 1));
                for (int b = 0; b < len; b++) begin
                    msg_q[i].push_back({(b == len - 1), 8'($urandom)});
                end
            end
        end
        run_until_idle(20000, "random_done");
        check("random_sends", 32'(sends - s0), 32'(pushed - p0));
        check("random_no_timeout", 32'(err_cnt - e0), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
